// File: rtl/wb_stage.sv
// wb_stage: write-back stage with load alignment, GPR/HI/LO/CP0 write ports and retire tracking
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic [4:0]       wb_wa,
  input  logic             wb_wreg,
  input  logic [31:0]      wb_dreg,
  input  logic             wb_mreg,
  input  logic [3:0]       wb_dre,
  input  logic             wb_extendtype,
  input  logic             wb_whilo,
  input  logic [63:0]      wb_hilo,
  input  logic [31:0]      dm_rdata,
  input  logic             wb_cp0_we,
  input  logic [4:0]       wb_cp0_waddr,
  input  logic [31:0]      wb_cp0_wdata,
  input  logic [31:0]      de_pc_i,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [31:0]      rf_wd,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic             cp0_we,
  output logic [4:0]       cp0_waddr,
  output logic [31:0]      cp0_wdata,
  output logic [31:0]      retired_pc,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             bad_dre
);
  logic [31:0] hi_q, lo_q, load_data;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic is_b, is_h, is_w, retire_ev;
  always_comb begin
    is_b = (wb_dre == 4'b0001) | (wb_dre == 4'b0010) | (wb_dre == 4'b0100) | (wb_dre == 4'b1000);
    is_h = (wb_dre == 4'b0011) | (wb_dre == 4'b1100);
    is_w = wb_dre == 4'b1111;
    ld_b = wb_dre[1] ? dm_rdata[15:8] : wb_dre[2] ? dm_rdata[23:16] : wb_dre[3] ? dm_rdata[31:24] : dm_rdata[7:0];
    ld_h = wb_dre[3] ? dm_rdata[31:16] : dm_rdata[15:0];
    load_data = is_b ? {{24{wb_extendtype & ld_b[7]}}, ld_b} :
                is_h ? {{16{wb_extendtype & ld_h[15]}}, ld_h} :
                is_w ? dm_rdata : 32'h0;
  end
  assign rf_we = wb_wreg & (wb_wa != 5'd0);
  assign rf_wa = wb_wa;
  assign rf_wd = wb_mreg ? load_data : wb_dreg;
  assign hi_o = wb_whilo ? wb_hilo[63:32] : hi_q;
  assign lo_o = wb_whilo ? wb_hilo[31:0] : lo_q;
  assign cp0_we = wb_cp0_we;
  assign cp0_waddr = wb_cp0_waddr;
  assign cp0_wdata = wb_cp0_wdata;
  assign retire_ev = (de_pc_i != 32'h0) & (de_pc_i != retired_pc);
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
      retired_pc <= 32'h0;
      retire_cnt <= '0;
      bad_dre <= 1'b0;
    end else begin
      if (wb_whilo) begin
        hi_q <= wb_hilo[63:32];
        lo_q <= wb_hilo[31:0];
      end
      if (retire_ev) begin
        retired_pc <= de_pc_i;
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (wb_mreg & ~(is_b | is_h | is_w)) bad_dre <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage
module tb_wb_stage;
  logic cpu_clk_50M = 1'b0;
  logic cpu_rst_n;
  logic [4:0] wb_wa, wb_cp0_waddr, rf_wa, cp0_waddr, rf_wa4, cp0_waddr4;
  logic wb_wreg, wb_mreg, wb_extendtype, wb_whilo, wb_cp0_we;
  logic [3:0] wb_dre;
  logic [31:0] wb_dreg, dm_rdata, wb_cp0_wdata, de_pc_i;
  logic [63:0] wb_hilo;
  logic rf_we, cp0_we, bad_dre, rf_we4, cp0_we4, bad_dre4;
  logic [31:0] rf_wd, hi_o, lo_o, cp0_wdata, retired_pc;
  logic [31:0] rf_wd4, hi_o4, lo_o4, cp0_wdata4, retired_pc4;
  logic [31:0] retire_cnt;
  logic [3:0] retire_cnt4;
  int n_chk = 0;
  int n_fail = 0;

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  wb_stage u_dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .wb_wa(wb_wa), .wb_wreg(wb_wreg),
    .wb_dreg(wb_dreg), .wb_mreg(wb_mreg), .wb_dre(wb_dre), .wb_extendtype(wb_extendtype),
    .wb_whilo(wb_whilo), .wb_hilo(wb_hilo), .dm_rdata(dm_rdata), .wb_cp0_we(wb_cp0_we),
    .wb_cp0_waddr(wb_cp0_waddr), .wb_cp0_wdata(wb_cp0_wdata), .de_pc_i(de_pc_i),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .hi_o(hi_o), .lo_o(lo_o),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .retired_pc(retired_pc), .retire_cnt(retire_cnt), .bad_dre(bad_dre)
  );

  wb_stage #(.CNT_W(4)) u_dut4 (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .wb_wa(wb_wa), .wb_wreg(wb_wreg),
    .wb_dreg(wb_dreg), .wb_mreg(wb_mreg), .wb_dre(wb_dre), .wb_extendtype(wb_extendtype),
    .wb_whilo(wb_whilo), .wb_hilo(wb_hilo), .dm_rdata(dm_rdata), .wb_cp0_we(wb_cp0_we),
    .wb_cp0_waddr(wb_cp0_waddr), .wb_cp0_wdata(wb_cp0_wdata), .de_pc_i(de_pc_i),
    .rf_we(rf_we4), .rf_wa(rf_wa4), .rf_wd(rf_wd4), .hi_o(hi_o4), .lo_o(lo_o4),
    .cp0_we(cp0_we4), .cp0_waddr(cp0_waddr4), .cp0_wdata(cp0_wdata4),
    .retired_pc(retired_pc4), .retire_cnt(retire_cnt4), .bad_dre(bad_dre4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    wb_wa = 5'd0; wb_wreg = 1'b0; wb_dreg = 32'h0; wb_mreg = 1'b0; wb_dre = 4'b0;
    wb_extendtype = 1'b0; wb_whilo = 1'b0; wb_hilo = 64'h0; dm_rdata = 32'h0;
    wb_cp0_we = 1'b0; wb_cp0_waddr = 5'd0; wb_cp0_wdata = 32'h0; de_pc_i = 32'h0;
    tick();
    tick();
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_pc", retired_pc, 0);
    check("rst_cnt", retire_cnt, 0);
    check("rst_bad", bad_dre, 0);
    cpu_rst_n = 1'b1;
    wb_mreg = 1'b1; dm_rdata = 32'h80FF_7F01; wb_dre = 4'b0100; wb_extendtype = 1'b1; #1;
    check("lb_lane2_sx", rf_wd, 32'hFFFF_FFFF);
    wb_extendtype = 1'b0; #1;
    check("lb_lane2_zx", rf_wd, 32'h0000_00FF);
    wb_dre = 4'b1100; wb_extendtype = 1'b1; #1;
    check("lh_hi_sx", rf_wd, 32'hFFFF_80FF);
    wb_dre = 4'b0011; #1;
    check("lh_lo_sx", rf_wd, 32'h0000_7F01);
    wb_dre = 4'b1000; #1;
    check("lb_lane3_sx", rf_wd, 32'hFFFF_FF80);
    wb_dre = 4'b0010; wb_extendtype = 1'b0; #1;
    check("lb_lane1_zx", rf_wd, 32'h0000_007F);
    wb_dre = 4'b1111; #1;
    check("lw", rf_wd, 32'h80FF_7F01);
    tick();
    check("bad_legal", bad_dre, 0);
    wb_mreg = 1'b0; wb_dreg = 32'hCAFE_0001; #1;
    check("alu_wd", rf_wd, 32'hCAFE_0001);
    wb_wreg = 1'b1; wb_wa = 5'd0; #1;
    check("we_r0", rf_we, 0);
    wb_wa = 5'd7; #1;
    check("we_r7", rf_we, 1);
    check("wa_r7", rf_wa, 7);
    wb_mreg = 1'b1; wb_dre = 4'b0101; #1;
    check("bad_wd", rf_wd, 0);
    check("bad_before", bad_dre, 0);
    tick();
    check("bad_set", bad_dre, 1);
    wb_dre = 4'b1111;
    tick();
    check("bad_sticky", bad_dre, 1);
    wb_mreg = 1'b0; wb_wreg = 1'b0;
    wb_whilo = 1'b1; wb_hilo = 64'h1234_5678_9ABC_DEF0; #1;
    check("hi_bypass", hi_o, 32'h1234_5678);
    check("lo_bypass", lo_o, 32'h9ABC_DEF0);
    check("hi_q_old", u_dut.hi_q, 0);
    tick();
    wb_whilo = 1'b0; wb_hilo = 64'h0; #1;
    check("hi_hold", hi_o, 32'h1234_5678);
    check("lo_hold", lo_o, 32'h9ABC_DEF0);
    wb_cp0_we = 1'b1; wb_cp0_waddr = 5'd12; wb_cp0_wdata = 32'hDEAD_BEEF; #1;
    check("cp0_we", cp0_we, 1);
    check("cp0_waddr", cp0_waddr, 12);
    check("cp0_wdata", cp0_wdata, 32'hDEAD_BEEF);
    wb_cp0_we = 1'b0;
    de_pc_i = 32'h100; tick();
    check("ret_first", retire_cnt, 1);
    tick();
    check("ret_stall", retire_cnt, 1);
    de_pc_i = 32'h0; tick();
    check("ret_bubble", retire_cnt, 1);
    de_pc_i = 32'h104; tick();
    check("ret_cnt", retire_cnt, 2);
    check("ret_pc", retired_pc, 32'h104);
    check("ret_cnt4", retire_cnt4, 2);
    cpu_rst_n = 1'b0; #1;
    check("mid_rst_cnt", retire_cnt, 0);
    check("mid_rst_pc", retired_pc, 0);
    check("mid_rst_hi", hi_o, 0);
    check("mid_rst_bad", bad_dre, 0);
    tick();
    cpu_rst_n = 1'b1;
    de_pc_i = 32'h108; tick();
    check("resume_cnt", retire_cnt, 1);
    check("resume_pc", retired_pc, 32'h108);
    cpu_rst_n = 1'b0; #1;
    cpu_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      de_pc_i = 32'h200 + 32'(i * 4);
      tick();
    end
    check("cnt4_full", retire_cnt4, 4'hF);
    de_pc_i = 32'h300; tick();
    check("cnt4_wrap", retire_cnt4, 0);
    check("cnt32_16", retire_cnt, 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
